// File: rtl/click_tx.sv
// click_tx: clocked 2-phase bundled-data transmitter feeding a click pipeline.
// Optional 4-entry input FIFO is enabled by defining CLICK_TX_FIFO_EN. Rev 1.0
`default_nettype none

module click_tx #(
  parameter int DW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int SYNC_STG  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data,
  output logic          out_req,
  input  logic          out_ack,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);

  state_t              state_q, state_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                out_req_q, out_req_d;
  logic [3:0]          setup_cnt_q, setup_cnt_d;
  logic                err_q, err_d;
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                ack_prev_q, ack_prev_d;
  logic                ack_s;
  logic                ack_edge;
  logic                load;
  logic [DW-1:0]       load_data;

`ifdef CLICK_TX_FIFO_EN
  logic [DW-1:0] fifo_mem_q [4];
  logic [DW-1:0] fifo_mem_d [4];
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          push, pop;

  assign push      = in_valid & in_ready_q;
  assign pop       = (state_q == IDLE) & (count_q != 3'd0);
  assign load      = pop;
  assign load_data = fifo_mem_q[rd_ptr_q];
  assign in_ready  = in_ready_q;

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = in_data;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d    = count_q + {2'b00, push} - {2'b00, pop};
    in_ready_d = (count_d != 3'd4);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      in_ready_q <= 1'b0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  assign in_ready  = (state_q == IDLE);
  assign load      = in_valid & in_ready;
  assign load_data = in_data;
`endif

  // Acknowledge crosses in from the click stage; the last stage is ack_s.
  assign ack_s    = sync_q[SYNC_STG-1];
  assign ack_edge = ack_s ^ ack_prev_q;

  always_comb begin
    sync_d     = {sync_q[SYNC_STG-2:0], out_ack};
    ack_prev_d = ack_s;
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_req_d   = out_req_q;
    setup_cnt_d = setup_cnt_q;
    // An ack edge outside WAIT_ACK breaks the phase invariant; flag and ignore it.
    err_d       = err_q | (ack_edge & (state_q != WAIT_ACK));
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d     = SETUP;
          out_data_d  = load_data;
          setup_cnt_d = 4'd0;
        end
      end
      SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d   = WAIT_ACK;
          out_req_d = ~out_req_q;
        end else if (setup_cnt_q != 4'hF) begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end
      WAIT_ACK: begin
        if (ack_s == out_req_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_req_q   <= 1'b0;
      setup_cnt_q <= 4'd0;
      err_q       <= 1'b0;
      sync_q      <= '0;
      ack_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_req_q   <= out_req_d;
      setup_cnt_q <= setup_cnt_d;
      err_q       <= err_d;
      sync_q      <= sync_d;
      ack_prev_q  <= ack_prev_d;
    end
  end

  assign out_data = out_data_q;
  assign out_req  = out_req_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_click_tx.sv
// tb_click_tx: directed self-checking bench for click_tx (defaults DW=2, SETUP_CYC=1, SYNC_STG=2).
// Define CLICK_TX_FIFO_EN for both files to exercise the FIFO build.
`default_nettype none

module tb_click_tx;
  localparam int DW        = 2;
  localparam int SETUP_CYC = 1;
  localparam int SYNC_STG  = 2;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          out_ack  = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_req;
  logic          busy;
  logic          err;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  click_tx #(.DW(DW), .SETUP_CYC(SETUP_CYC), .SYNC_STG(SYNC_STG)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_data (out_data),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .busy     (busy),
    .err      (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    out_ack  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    out_ack  = 1'b0;
    #2;
`ifdef CLICK_TX_FIFO_EN
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
`else
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`endif
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    vec++; if (out_req !== 1'b0) begin errs++; $display("FAIL idle_out_req got %b want 0", out_req); end
    vec++; if (out_data !== 2'b00) begin errs++; $display("FAIL idle_out_data got %b want 00", out_data); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
    vec++; if (err !== 1'b0) begin errs++; $display("FAIL idle_err got %b want 0", err); end
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_send;
    in_valid = 1'b1;
    in_data  = 2'b10;
    tick();
    in_valid = 1'b0;
    vec++; if (out_data !== 2'b10) begin errs++; $display("FAIL send_data got %b want 10", out_data); end
    vec++; if (out_req !== 1'b0) begin errs++; $display("FAIL send_req_early got %b want 0", out_req); end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL send_busy got %b want 1", busy); end
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL send_in_ready got %b want 0", in_ready); end
    tick();
    vec++; if (out_req !== 1'b1) begin errs++; $display("FAIL send_req_toggle got %b want 1", out_req); end
    repeat (3) tick();
    out_ack = 1'b1;
    tick();
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL send_busy_ack1 got %b want 1", busy); end
    tick();
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL send_busy_ack2 got %b want 1", busy); end
    vec++; if (out_data !== 2'b10) begin errs++; $display("FAIL send_data_hold got %b want 10", out_data); end
    tick();
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL send_busy_ack3 got %b want 0", busy); end
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL send_ready_ack3 got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] words [3];
    logic          exp_req;
    int            nb;
    words[0] = 2'b10;
    words[1] = 2'b01;
    words[2] = 2'b11;
    do_reset();
    exp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
      in_valid = 1'b0;
      exp_req  = ~exp_req;
      nb       = 1;
      vec++; if (out_data !== words[i]) begin errs++; $display("FAIL b2b_data[%0d] got %b want %b", i, out_data, words[i]); end
      tick();
      nb++;
      vec++; if (out_req !== exp_req) begin errs++; $display("FAIL b2b_req[%0d] got %b want %b", i, out_req, exp_req); end
      out_ack = exp_req;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (busy !== 1'b1) break;
        nb++;
        vec++; if (out_data !== words[i]) begin errs++; $display("FAIL b2b_hold[%0d] got %b want %b", i, out_data, words[i]); end
      end
      vec++; if (nb != 4) begin errs++; $display("FAIL b2b_cycles[%0d] got %0d want 4", i, nb); end
      vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_spurious;
    bit done;
    out_ack = 1'b0;
    tick();
    tick();
    vec++; if (err !== 1'b0) begin errs++; $display("FAIL spur_err_early got %b want 0", err); end
    tick();
    vec++; if (err !== 1'b1) begin errs++; $display("FAIL spur_err got %b want 1", err); end
    in_valid = 1'b1;
    in_data  = 2'b11;
    tick();
    in_valid = 1'b0;
    tick();
    vec++; if (out_req !== 1'b0) begin errs++; $display("FAIL spur_req got %b want 0", out_req); end
    done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy === 1'b0) begin done = 1'b1; break; end
    end
    vec++; if (!done) begin errs++; $display("FAIL spur_complete got busy=%b want 0 within 10 cycles", busy); end
    vec++; if (err !== 1'b1) begin errs++; $display("FAIL spur_err_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid;
    bit done;
    in_valid = 1'b1;
    in_data  = 2'b10;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy_before got %b want 1", busy); end
    reset_n = 1'b0;
    out_ack = 1'b0;
    #1;
    vec++; if (out_req !== 1'b0) begin errs++; $display("FAIL mid_req got %b want 0", out_req); end
    vec++; if (out_data !== 2'b00) begin errs++; $display("FAIL mid_data got %b want 00", out_data); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got %b want 0", busy); end
    vec++; if (err !== 1'b0) begin errs++; $display("FAIL mid_err got %b want 0", err); end
    tick();
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = 2'b01;
    tick();
    in_valid = 1'b0;
    vec++; if (out_data !== 2'b01) begin errs++; $display("FAIL post_data got %b want 01", out_data); end
    tick();
    vec++; if (out_req !== 1'b1) begin errs++; $display("FAIL post_req got %b want 1", out_req); end
    out_ack = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy === 1'b0) begin done = 1'b1; break; end
    end
    vec++; if (!done) begin errs++; $display("FAIL post_complete got busy=%b want 0 within 10 cycles", busy); end
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL post_ready got %b want 1", in_ready); end
    vec++; if (err !== 1'b0) begin errs++; $display("FAIL post_err got %b want 0", err); end
  endtask

  task automatic test_fifo;
    logic [DW-1:0] words [5];
    logic          exp_req;
    bit            seen;
    words[0] = 2'b01;
    words[1] = 2'b10;
    words[2] = 2'b11;
    words[3] = 2'b00;
    words[4] = 2'b10;
    for (int k = 0; k < 5; k++) begin
      vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fifo_ready_push[%0d] got %b want 1", k, in_ready); end
      in_valid = 1'b1;
      in_data  = words[k];
      tick();
    end
    in_valid = 1'b0;
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fifo_full got %b want 0", in_ready); end
    exp_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_req = ~exp_req;
      seen    = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (out_req === exp_req) begin seen = 1'b1; break; end
        tick();
      end
      vec++; if (!seen) begin errs++; $display("FAIL fifo_req[%0d] got %b want %b within 20 cycles", k, out_req, exp_req); end
      vec++; if (out_data !== words[k]) begin errs++; $display("FAIL fifo_order[%0d] got %b want %b", k, out_data, words[k]); end
      out_ack = exp_req;
    end
    repeat (8) tick();
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL fifo_drain_busy got %b want 0", busy); end
    vec++; if (out_req !== 1'b1) begin errs++; $display("FAIL fifo_toggles got req %b want 1 after 5 toggles", out_req); end
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fifo_ready_end got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
`ifdef CLICK_TX_FIFO_EN
    test_fifo();
`else
    test_send();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/click_tx.md
# click_tx

Clocked transmitter that drives the input channel of a click pipeline (`click_buf` chain). It uses the 2-phase bundled-data handshake: each transfer is one toggle of `out_req`, and completion is one toggle of `out_ack`. Upstream synchronous logic hands it words over a valid/ready interface. The block holds the data stable, waits a programmable bundling delay, toggles the request, then waits for the synchronized acknowledge before releasing the channel.

## Interface
- `DW`, 2, data width in bits.
- `SETUP_CYC`, 1, clock cycles between `out_data` becoming valid and the `out_req` toggle; legal range 1..15.
- `SYNC_STG`, 2, synchronizer flops on `out_ack`; legal range 2..3.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream word available.
- `in_ready`  output  1  block accepts a word this cycle.
- `in_data`  input  DW  upstream word; sampled when `in_valid & in_ready`.
- `out_data`  output  DW  bundled data to the click stage; registered; stable from load until the matching ack is seen.
- `out_req`  output  1  2-phase request; one toggle per word; registered.
- `out_ack`  input  1  2-phase acknowledge from the click stage; asynchronous to `clk`.
- `busy`  output  1  high whenever the FSM is not in IDLE.
- `err`  output  1  sticky protocol error; cleared only by reset.

## Operation
- FSM states:
  - IDLE: channel free.
  - SETUP: data loaded, bundling delay counting.
  - WAIT_ACK: `out_req` toggled, awaiting ack.
- Transitions:
  - IDLE -> SETUP on a word accept (or non-empty FIFO); `out_data` loads and `setup_cnt` clears.
  - SETUP -> WAIT_ACK when `setup_cnt == SETUP_CYC-1`; `out_req` toggles on that edge.
  - WAIT_ACK -> IDLE when `ack_s == out_req`.
- Ack path:
  - `out_ack` passes through `SYNC_STG` flops to form `ack_s`.
  - `ack_prev` holds the last `ack_s`; an edge is `ack_s ^ ack_prev`.
- Without FIFO: `in_ready = (state == IDLE)`, combinational from state only.
- Phase invariant: in IDLE and SETUP, `ack_s == out_req`.
  - A detected ack edge in IDLE or SETUP sets `err`.
  - The FSM ignores that edge and continues.
- `out_data` changes only on the IDLE->SETUP edge; never during SETUP or WAIT_ACK.
- `setup_cnt` is 4 bits; it saturates and is never compared beyond `SETUP_CYC-1`.

## Timing
- Reset values: `out_req`=0, `out_data`=0, `busy`=0, `err`=0, sync flops=0, state=IDLE.
- `in_ready` is 1 during reset (no-FIFO build) and 0 during reset (FIFO build, because the output is registered there).
- Accept at edge t:
  - `out_data` valid after t.
  - `out_req` toggles at edge t+`SETUP_CYC`.
- Acknowledge path:
  - An ack toggle arriving before edge a is seen in `ack_s` after edge a+`SYNC_STG`-1.
  - The FSM enters IDLE on the next edge.
  - `in_ready` rises that same cycle.
- Minimum cycles per word (ack returned instantly): `SETUP_CYC` + `SYNC_STG` + 1; 4 with defaults.
- The FSM never issues back-to-back toggles; at most one request is outstanding.
- Ack edge and a new accept in the same cycle: cannot occur in the no-FIFO build, since accept requires IDLE.
- Reset asserted mid-transfer:
  - All outputs return to reset values immediately (asynchronous).
  - Any in-flight word is dropped.
  - The downstream click stage must be reset in the same window so that phase parity matches.

## Configuration
- `CLICK_TX_FIFO_EN` defined:
  - A 4-entry synchronous FIFO sits between the valid/ready port and the FSM.
  - `in_ready = !full`, registered.
  - The FSM pops in IDLE when non-empty, so a pop and a push may coincide; occupancy is unchanged in that case.
  - Push when full is impossible, because `in_ready` is 0.
  - Pointers are 2 bits and wrap modulo 4; full/empty use a 3-bit count.
  - Latency from accept to `out_data` grows by 1 cycle.
- Undefined: no FIFO; single holding register as described in Operation.

## Test plan
- Reset release, then idle 5 cycles:
  - `out_req`=0, `out_data`=0, `busy`=0, `err`=0.
  - `in_ready`=1 (no-FIFO).
- Send 2'b10; model acks 3 cycles after req:
  - `out_data`=10 one edge after accept.
  - `out_req` 0->1 at accept+1.
  - `busy` drops and `in_ready` rises 3 cycles after the ack toggle.
- Back-to-back 2'b10, 2'b01, 2'b11 with instant ack:
  - `out_req` toggles 1, 0, 1.
  - Each `out_data` is held stable until its ack.
  - 4 cycles per word.
- Inject a spurious `out_ack` toggle while IDLE:
  - `err`=1 after `SYNC_STG`+1 cycles.
  - A subsequent transfer still completes.
- Assert `reset_n`=0 during WAIT_ACK:
  - `out_req`, `out_data`, `busy` return to 0 immediately.
  - After release, a transfer of 2'b01 completes normally.
- FIFO build, ack withheld:
  - Push 5 words: `in_ready` falls after the 4th stored (first word in flight).
  - Release acks: words emerge in order, 5 toggles total.
